// File: rtl/mips_fetch_pkg.sv
// Shared constants, entry type and opcode helpers for the MIPS fetch/decode slice.
package mips_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [5:0] OPCODE_J   = 6'b000010;
  localparam logic [5:0] OPCODE_JAL = 6'b000011;

  // Field slice bounds within an instruction word
  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 26;
  localparam int unsigned JIDX_MSB = 25;
  localparam int unsigned JIDX_LSB = 0;

  // One prefetch entry: word address plus the instruction fetched from it
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // True for the unconditional jumps that fetch can resolve on its own
  function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
    return (instr[OPC_MSB:OPC_LSB] == OPCODE_J) || (instr[OPC_MSB:OPC_LSB] == OPCODE_JAL);
  endfunction

endpackage

// File: rtl/mod_fetch_fifo.sv
// Small prefetch FIFO of {pc, instruction} entries with a registered head and synchronous flush.
module mod_fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  fetch_entry_t                 i_wdata,
  output logic                         o_full,
  output logic                         o_empty,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  fetch_entry_t       r_head;
  logic               w_push;
  logic               w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_head;
  assign o_count = r_count;

  // Qualify requests so the FIFO never overruns or underruns on its own
  always_comb begin
    w_pop  = i_pop & ~o_empty;
    w_push = i_push & (~o_full | w_pop);
  end

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers, occupancy and head register; the head keeps its last value once drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      // Head takes the pushed word when it becomes the only entry, else the next stored one
      if (w_push && ((r_count == '0) || (w_pop && r_count == CNT_W'(1))))
        r_head <= i_wdata;
      else if (w_pop && r_count > CNT_W'(1))
        r_head <= r_mem[ptr_inc(r_rd_ptr)];
    end
  end

endmodule

// File: rtl/mod_instruction_fetch_unit.sv
// Instruction fetch: owns the pc, drives the ROM, pre-decodes J/JAL and buffers fetched words.
module mod_instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH     = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR     = 32'd0,
  parameter int unsigned       JUMP_PREDECODE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [INSTR_W-1:0]  rom_instruction,
  input  logic                fetch_en,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instruction,
  output logic [ADDR_W-1:0]   out_pc
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_plus1;
  logic [ADDR_W-1:0]  w_next_pc;
  logic               w_is_jump;
  logic               w_pop;
  logic               w_can_push;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  fetch_entry_t       w_push_data;
  fetch_entry_t       w_head;

  assign rom_address     = r_pc;
  assign out_valid       = ~w_empty;
  assign out_instruction = w_head.instr;
  assign out_pc          = w_head.pc;

  // Next-pc selection and push/pop qualification; redirect suppresses any push
  always_comb begin
    w_pc_plus1  = r_pc + 32'd1;
    w_is_jump   = (JUMP_PREDECODE != 0) && is_jump(rom_instruction);
    w_next_pc   = w_is_jump ? {w_pc_plus1[ADDR_W-1:OPC_LSB], rom_instruction[JIDX_MSB:JIDX_LSB]}
                            : w_pc_plus1;
    w_pop       = out_valid & out_ready;
    w_can_push  = fetch_en & ~redirect_valid & ((32'(w_count) < FIFO_DEPTH) | w_pop);
    w_push_data = '{pc: r_pc, instr: rom_instruction};
  end

  // Program counter: redirect wins, otherwise advance only when the fetched word is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_pc <= RESET_ADDR;
    else if (redirect_valid) r_pc <= redirect_addr;
    else if (w_can_push)     r_pc <= w_next_pc;
  end

  mod_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_can_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (w_count)
  );

  a_full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
    w_full == (32'(w_count) == FIFO_DEPTH));

endmodule

// File: tb/tb_mod_instruction_fetch_unit.sv
// Directed bench for the fetch unit: sequencing, jumps, back-pressure, redirect, wrap and reset.
module tb_mod_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_address;
  logic [31:0] rom_instruction;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  logic        rst_n2;
  logic [31:0] rom_address2;
  logic [31:0] rom_instruction2;
  logic        fetch_en2;
  logic        redirect_valid2;
  logic [31:0] redirect_addr2;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] out_instruction2;
  logic [31:0] out_pc2;

  int unsigned n_checks;
  int unsigned n_errors;

  mod_instruction_fetch_unit #(
    .FIFO_DEPTH     (2),
    .RESET_ADDR     (32'd0),
    .JUMP_PREDECODE (1)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
  );

  mod_instruction_fetch_unit #(
    .FIFO_DEPTH     (2),
    .RESET_ADDR     (32'hFFFF_FFFE),
    .JUMP_PREDECODE (1)
  ) u_dut_wrap (
    .clk             (clk),
    .rst_n           (rst_n2),
    .rom_address     (rom_address2),
    .rom_instruction (rom_instruction2),
    .fetch_en        (fetch_en2),
    .redirect_valid  (redirect_valid2),
    .redirect_addr   (redirect_addr2),
    .out_valid       (out_valid2),
    .out_ready       (out_ready2),
    .out_instruction (out_instruction2),
    .out_pc          (out_pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_model(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0022_1820;
      32'd1:   return 32'h0485_FFFF;
      32'd2:   return 32'h0800_0020;
      default: return 32'h0000_0000;
    endcase
  endfunction

  always_comb rom_instruction = rom_model(rom_address);
  assign rom_instruction2 = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    out_ready      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_pc [5];
  logic [31:0] exp_in [5];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0; out_ready = 1'b0;
    rst_n2 = 1'b0; fetch_en2 = 1'b0; redirect_valid2 = 1'b0; redirect_addr2 = 32'h0; out_ready2 = 1'b1;
    exp_pc = '{32'd0, 32'd1, 32'd2, 32'd32, 32'd33};
    exp_in = '{32'h0022_1820, 32'h0485_FFFF, 32'h0800_0020, 32'h0, 32'h0};

    // 1: reset state, then straight-line fetch through a J with no bubble
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", rom_address, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instruction, 32'd0);
    rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("seq_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("seq_pc%0d", i), out_pc, exp_pc[i]);
      check($sformatf("seq_instr%0d", i), out_instruction, exp_in[i]);
    end

    // 2: back-pressure saturates the FIFO, then drains in order
    do_reset();
    fetch_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 2) begin
        check($sformatf("stall_addr%0d", i), rom_address, 32'd2);
        check($sformatf("stall_pc%0d", i), out_pc, 32'd0);
      end
    end
    check("stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick(); check("drain_pc1", out_pc, 32'd1);
    tick(); check("drain_pc2", out_pc, 32'd2);
    tick(); check("drain_pc32", out_pc, 32'd32);

    // 3: redirect while holding pc 1,2
    do_reset();
    fetch_en = 1'b1;
    tick(); tick();
    out_ready = 1'b1;
    tick();
    check("r3_head", out_pc, 32'd1);
    check("r3_addr", rom_address, 32'd32);
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'd100;
    tick();
    check("r3_flush_valid", 32'(out_valid), 32'd0);
    check("r3_flush_addr", rom_address, 32'd100);
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("r3_tgt_valid", 32'(out_valid), 32'd1);
    check("r3_tgt_pc", out_pc, 32'd100);
    tick();
    check("r3_tgt_pc1", out_pc, 32'd101);

    // 4: redirect coinciding with a pop on a full FIFO
    do_reset();
    fetch_en = 1'b1;
    tick(); tick();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'd200;
    tick();
    check("r4_flush_valid", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("r4_tgt_valid", 32'(out_valid), 32'd1);
    check("r4_tgt_pc", out_pc, 32'd200);
    tick();
    check("r4_tgt_pc1", out_pc, 32'd201);

    // 5: address wrap from the top of the word space
    check("w_rst_addr", rom_address2, 32'hFFFF_FFFE);
    check("w_rst_valid", 32'(out_valid2), 32'd0);
    rst_n2 = 1'b1; fetch_en2 = 1'b1;
    tick(); check("w_pc0", out_pc2, 32'hFFFF_FFFE);
    tick(); check("w_pc1", out_pc2, 32'hFFFF_FFFF);
    check("w_addr_wrap", rom_address2, 32'h0);
    tick(); check("w_pc2", out_pc2, 32'h0);

    // 6: asynchronous reset mid-stream, fetch_en stall/drain, redirect while idle
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    check("a_pre_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("a_valid", 32'(out_valid), 32'd0);
    check("a_addr", rom_address, 32'd0);
    check("a_pc", out_pc, 32'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b0;
    tick();
    check("a_restart_pc", out_pc, 32'd0);
    check("a_restart_valid", 32'(out_valid), 32'd1);
    tick();
    fetch_en = 1'b0; out_ready = 1'b1;
    tick();
    check("fe_addr0", rom_address, 32'd2);
    check("fe_pc0", out_pc, 32'd1);
    tick();
    check("fe_addr1", rom_address, 32'd2);
    check("fe_empty1", 32'(out_valid), 32'd0);
    check("fe_hold_pc", out_pc, 32'd1);
    tick();
    check("fe_addr2", rom_address, 32'd2);
    check("fe_empty2", 32'(out_valid), 32'd0);
    fetch_en = 1'b1;
    tick();
    check("fe_resume_pc", out_pc, 32'd2);
    check("fe_resume_instr", out_instruction, 32'h0800_0020);
    fetch_en = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'd300;
    tick();
    check("ri_addr", rom_address, 32'd300);
    check("ri_valid", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("ri_idle_addr", rom_address, 32'd300);
    check("ri_idle_valid", 32'(out_valid), 32'd0);
    fetch_en = 1'b1;
    tick();
    check("ri_tgt_pc", out_pc, 32'd300);
    check("ri_tgt_valid", 32'(out_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
